// File: rtl/xs_axi_mem_responder.sv
// ----------------------------------------------------------------------------
// xs_axi_mem_responder
//
// AXI4 slave that terminates a 256-bit memory port with an internal SRAM
// window [MEM_BASE, MEM_BASE + MEM_WORDS*32). Write and read channels run
// independent FSMs, each with one outstanding burst.
//
// Ports
//   io_clock, io_reset_n          clock, asynchronous active-low reset
//   memory_aw* / memory_w* / memory_b*   write address, data, response
//   memory_ar* / memory_r*               read address, data
//   memory_{aw,ar}{lock,cache,prot,qos}  accepted and ignored
//
// Responses: DECERR outside the window, SLVERR for WRAP/reserved bursts or
// size > 5, OKAY otherwise. The storage array is never reset.
// ----------------------------------------------------------------------------
module xs_axi_mem_responder #(
    parameter int                  ID_W      = 14,
    parameter int                  ADDR_W    = 48,
    parameter int                  DATA_W    = 256,
    parameter logic [ADDR_W-1:0]   MEM_BASE  = 48'h8000_0000,
    parameter int                  MEM_WORDS = 4096
) (
    input  logic                 io_clock,
    input  logic                 io_reset_n,
    input  logic                 memory_awvalid,
    output logic                 memory_awready,
    input  logic [ID_W-1:0]      memory_awid,
    input  logic [ADDR_W-1:0]    memory_awaddr,
    input  logic [7:0]           memory_awlen,
    input  logic [2:0]           memory_awsize,
    input  logic [1:0]           memory_awburst,
    input  logic                 memory_awlock,
    input  logic [3:0]           memory_awcache,
    input  logic [2:0]           memory_awprot,
    input  logic [3:0]           memory_awqos,
    input  logic                 memory_wvalid,
    output logic                 memory_wready,
    input  logic [DATA_W-1:0]    memory_wdata,
    input  logic [DATA_W/8-1:0]  memory_wstrb,
    input  logic                 memory_wlast,
    output logic                 memory_bvalid,
    input  logic                 memory_bready,
    output logic [ID_W-1:0]      memory_bid,
    output logic [1:0]           memory_bresp,
    input  logic                 memory_arvalid,
    output logic                 memory_arready,
    input  logic [ID_W-1:0]      memory_arid,
    input  logic [ADDR_W-1:0]    memory_araddr,
    input  logic [7:0]           memory_arlen,
    input  logic [2:0]           memory_arsize,
    input  logic [1:0]           memory_arburst,
    input  logic                 memory_arlock,
    input  logic [3:0]           memory_arcache,
    input  logic [2:0]           memory_arprot,
    input  logic [3:0]           memory_arqos,
    output logic                 memory_rvalid,
    input  logic                 memory_rready,
    output logic [ID_W-1:0]      memory_rid,
    output logic [DATA_W-1:0]    memory_rdata,
    output logic [1:0]           memory_rresp,
    output logic                 memory_rlast
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(MEM_WORDS) << 5;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;
    localparam logic [1:0] RESP_DEC  = 2'b11;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Response codes are ordered so that the numerically larger one is worse.
    function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [1:0] f_class(input logic [ADDR_W-1:0] a,
                                           input logic [2:0] sz, input logic [1:0] bt);
        if (a < MEM_BASE || (a - MEM_BASE) >= WIN_BYTES) return RESP_DEC;
        if (bt[1] || sz > 3'd5)                           return RESP_SLV;
        return RESP_OKAY;
    endfunction

    // Only INCR advances; FIXED and the unsupported kinds stay put.
    function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a,
                                                 input logic [2:0] sz, input logic [1:0] bt);
        logic [ADDR_W-1:0] step;
        step = ADDR_W'(1) << sz;
        if (bt == BURST_INCR) return (a & ~(step - ADDR_W'(1))) + step;
        return a;
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - MEM_BASE) >> 5);
    endfunction

    // Holds the ready outputs low for the first edge after reset release.
    logic live_q;

    w_state_t            w_state_q, w_state_d;
    logic [ID_W-1:0]     w_id_q;
    logic [ADDR_W-1:0]   w_addr_q;
    logic [7:0]          w_len_q, w_cnt_q;
    logic [2:0]          w_size_q;
    logic [1:0]          w_burst_q, w_resp_q;

    r_state_t            r_state_q, r_state_d;
    logic [ID_W-1:0]     r_id_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [7:0]          r_len_q, r_cnt_q;
    logic [2:0]          r_size_q;
    logic [1:0]          r_burst_q, r_resp_q;
    logic                r_last_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [1:0]          w_beat_resp, w_resp_acc;
    logic                w_is_last;
    logic [ADDR_W-1:0]   r_nxt_addr, rd_addr;
    logic [7:0]          r_cnt_nxt;
    logic                rd_load, w_en;
    logic [DATA_W-1:0]   mem_rd;

    assign aw_hs = memory_awvalid & memory_awready;
    assign w_hs  = memory_wvalid  & memory_wready;
    assign b_hs  = memory_bvalid  & memory_bready;
    assign ar_hs = memory_arvalid & memory_arready;
    assign r_hs  = memory_rvalid  & memory_rready;

    assign w_beat_resp = f_class(w_addr_q, w_size_q, w_burst_q);
    assign w_is_last   = (w_cnt_q == w_len_q);
    // A misplaced wlast only degrades a clean burst to SLVERR.
    assign w_resp_acc  = f_worst(f_worst(w_resp_q, w_beat_resp),
                                 (memory_wlast != w_is_last) ? RESP_SLV : RESP_OKAY);
    assign w_en        = w_hs && (w_beat_resp == RESP_OKAY);

    assign r_nxt_addr = f_next(r_addr_q, r_size_q, r_burst_q);
    assign r_cnt_nxt  = r_cnt_q + 8'd1;
    // Read port loads beat 0 on AR, then the following beat on each non-final R.
    assign rd_load    = ar_hs | (r_hs & ~r_last_q);
    assign rd_addr    = ar_hs ? memory_araddr : r_nxt_addr;

    // ---------------- state registers ----------------
    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs)             w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_is_last) w_state_d = W_RESP;
            W_RESP:  if (b_hs)              w_state_d = W_IDLE;
            default:                        w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)            r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_last_q) r_state_d = R_IDLE;
            default:                       r_state_d = R_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        memory_awready = live_q && (w_state_q == W_IDLE);
        memory_wready  = (w_state_q == W_DATA);
        memory_bvalid  = (w_state_q == W_RESP);
        memory_arready = live_q && (r_state_q == R_IDLE);
        memory_rvalid  = (r_state_q == R_DATA);
        memory_bid     = w_id_q;
        memory_bresp   = w_resp_q;
        memory_rid     = r_id_q;
        memory_rresp   = r_resp_q;
        memory_rlast   = r_last_q;
        memory_rdata   = (memory_rvalid && r_resp_q == RESP_OKAY) ? mem_rd : '0;
    end

    // ---------------- request / beat tracking ----------------
    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            w_id_q <= '0; w_addr_q <= '0; w_len_q <= '0; w_cnt_q <= '0;
            w_size_q <= '0; w_burst_q <= '0; w_resp_q <= RESP_OKAY;
        end else if (aw_hs) begin
            w_id_q    <= memory_awid;
            w_addr_q  <= memory_awaddr;
            w_len_q   <= memory_awlen;
            w_size_q  <= memory_awsize;
            w_burst_q <= memory_awburst;
            w_cnt_q   <= '0;
            w_resp_q  <= RESP_OKAY;
        end else if (w_hs) begin
            w_addr_q  <= f_next(w_addr_q, w_size_q, w_burst_q);
            w_cnt_q   <= w_cnt_q + 8'd1;
            w_resp_q  <= w_resp_acc;
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            r_id_q <= '0; r_addr_q <= '0; r_len_q <= '0; r_cnt_q <= '0;
            r_size_q <= '0; r_burst_q <= '0; r_resp_q <= RESP_OKAY; r_last_q <= 1'b0;
        end else if (ar_hs) begin
            r_id_q    <= memory_arid;
            r_addr_q  <= memory_araddr;
            r_len_q   <= memory_arlen;
            r_size_q  <= memory_arsize;
            r_burst_q <= memory_arburst;
            r_cnt_q   <= '0;
            r_resp_q  <= f_class(memory_araddr, memory_arsize, memory_arburst);
            r_last_q  <= (memory_arlen == 8'd0);
        end else if (r_hs && !r_last_q) begin
            r_addr_q  <= r_nxt_addr;
            r_cnt_q   <= r_cnt_nxt;
            r_resp_q  <= f_class(r_nxt_addr, r_size_q, r_burst_q);
            r_last_q  <= (r_cnt_nxt == r_len_q);
        end
    end

    // ---------------- storage: one byte-wide RAM per lane ----------------
    // Read and write share the edge; the read register sees pre-write data.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_WORDS];
        logic [7:0] lane_rd_q;
        always_ff @(posedge io_clock) begin
            if (w_en && memory_wstrb[gi])
                lane_mem[f_idx(w_addr_q)] <= memory_wdata[gi*8 +: 8];
            if (rd_load)
                lane_rd_q <= lane_mem[f_idx(rd_addr)];
        end
        assign mem_rd[gi*8 +: 8] = lane_rd_q;
    end

    logic unused_sideband;
    assign unused_sideband = ^{memory_awlock, memory_awcache, memory_awprot, memory_awqos,
                               memory_arlock, memory_arcache, memory_arprot, memory_arqos};
endmodule

// File: tb/tb_xs_axi_mem_responder.sv
module tb_xs_axi_mem_responder;
    localparam int ID_W = 14;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 256;
    localparam int STRB_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              awvalid = 0, awready;
    logic [ID_W-1:0]   awid = 0;
    logic [ADDR_W-1:0] awaddr = 0;
    logic [7:0]        awlen = 0;
    logic [2:0]        awsize = 0;
    logic [1:0]        awburst = 0;
    logic              wvalid = 0, wready, wlast = 0;
    logic [DATA_W-1:0] wdata = 0;
    logic [STRB_W-1:0] wstrb = 0;
    logic              bvalid, bready = 1;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arvalid = 0, arready;
    logic [ID_W-1:0]   arid = 0;
    logic [ADDR_W-1:0] araddr = 0;
    logic [7:0]        arlen = 0;
    logic [2:0]        arsize = 0;
    logic [1:0]        arburst = 0;
    logic              rvalid, rready = 1, rlast;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    xs_axi_mem_responder dut (
        .io_clock(clk), .io_reset_n(rst_n),
        .memory_awvalid(awvalid), .memory_awready(awready), .memory_awid(awid),
        .memory_awaddr(awaddr), .memory_awlen(awlen), .memory_awsize(awsize),
        .memory_awburst(awburst), .memory_awlock(1'b0), .memory_awcache(4'h0),
        .memory_awprot(3'h0), .memory_awqos(4'h0),
        .memory_wvalid(wvalid), .memory_wready(wready), .memory_wdata(wdata),
        .memory_wstrb(wstrb), .memory_wlast(wlast),
        .memory_bvalid(bvalid), .memory_bready(bready), .memory_bid(bid), .memory_bresp(bresp),
        .memory_arvalid(arvalid), .memory_arready(arready), .memory_arid(arid),
        .memory_araddr(araddr), .memory_arlen(arlen), .memory_arsize(arsize),
        .memory_arburst(arburst), .memory_arlock(1'b0), .memory_arcache(4'h0),
        .memory_arprot(3'h0), .memory_arqos(4'h0),
        .memory_rvalid(rvalid), .memory_rready(rready), .memory_rid(rid),
        .memory_rdata(rdata), .memory_rresp(rresp), .memory_rlast(rlast)
    );

    int total = 0;
    int bad = 0;

    typedef struct { logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
    r_exp_t exp_r[$];
    b_exp_t exp_b[$];

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_r(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                          input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        exp_r.push_back(e);
    endtask

    task automatic push_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        exp_b.push_back(e);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT completes a beat.
    always @(negedge clk) begin : monitor
        r_exp_t er;
        b_exp_t eb;
        if (rst_n && rvalid && rready) begin
            $display("R id=%h resp=%0d last=%0d data=%h", rid, rresp, rlast, rdata);
            if (exp_r.size() == 0) begin
                total++; bad++;
                $display("FAIL r_unexpected actual=beat id %h required=no beat", rid);
            end else begin
                er = exp_r.pop_front();
                chk("rid", DATA_W'(rid), DATA_W'(er.id));
                chk("rresp", DATA_W'(rresp), DATA_W'(er.resp));
                chk("rlast", DATA_W'(rlast), DATA_W'(er.last));
                chk("rdata", rdata, er.data);
            end
        end
        if (rst_n && bvalid && bready) begin
            $display("B id=%h resp=%0d", bid, bresp);
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected actual=resp id %h required=no resp", bid);
            end else begin
                eb = exp_b.pop_front();
                chk("bid", DATA_W'(bid), DATA_W'(eb.id));
                chk("bresp", DATA_W'(bresp), DATA_W'(eb.resp));
            end
        end
    end

    task automatic do_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                         input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
        int n;
        @(posedge clk); #1;
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 100);
        if (!awready) begin total++; bad++; $display("FAIL aw_timeout actual=no awready required=awready"); end
        @(posedge clk); #1 awvalid = 0;
    endtask

    task automatic do_w(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s, input logic last);
        int n;
        @(posedge clk); #1;
        wdata = d; wstrb = s; wlast = last; wvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!wready && n < 100);
        if (!wready) begin total++; bad++; $display("FAIL w_timeout actual=no wready required=wready"); end
        @(posedge clk); #1 wvalid = 0; wlast = 0;
    endtask

    task automatic do_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                         input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
        int n;
        @(posedge clk); #1;
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 100);
        if (!arready) begin total++; bad++; $display("FAIL ar_timeout actual=no arready required=arready"); end
        @(posedge clk); #1 arvalid = 0;
    endtask

    task automatic wait_b();
        int n = 0;
        while (exp_b.size() > 0 && n < 100) begin @(negedge clk); n++; end
        chk("b_pending", DATA_W'(exp_b.size()), '0);
    endtask

    task automatic wait_r();
        int n = 0;
        while (exp_r.size() > 0 && n < 200) begin @(negedge clk); n++; end
        chk("r_pending", DATA_W'(exp_r.size()), '0);
    endtask

    function automatic logic [DATA_W-1:0] rep32(input logic [31:0] w);
        return {8{w}};
    endfunction

    function automatic logic [15:0] out_flags();
        return {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, 6'd0};
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int beats;
        int cyc;
        logic have_held;
        logic [DATA_W-1:0] held;
        logic [ADDR_W-1:0] top_addr;

        // ---- power-on reset ----
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", DATA_W'(out_flags()), '0);
        chk("rst_ids", DATA_W'({bid, rid}), '0);
        chk("rst_rdata", rdata, '0);
        rst_n = 1;
        @(negedge clk);
        chk("rel_awready", DATA_W'(awready), DATA_W'(1'b1));
        chk("rel_arready", DATA_W'(arready), DATA_W'(1'b1));

        // ---- 4-beat INCR write then read ----
        do_aw(14'h12, 48'h8000_0040, 8'd3, 3'd5, 2'b01);
        push_b(14'h12, 2'b00);
        for (int k = 0; k < 4; k++) do_w(rep32(32'hA0 + k), '1, k == 3);
        wait_b();
        for (int k = 0; k < 4; k++) push_r(14'h34, rep32(32'hA0 + k), 2'b00, k == 3);
        do_ar(14'h34, 48'h8000_0040, 8'd3, 3'd5, 2'b01);
        wait_r();

        // ---- partial strobe ----
        do_aw(14'h1, 48'h8000_0000, 8'd0, 3'd5, 2'b01);
        push_b(14'h1, 2'b00);
        do_w('1, '1, 1'b1);
        wait_b();
        do_aw(14'h2, 48'h8000_0000, 8'd0, 3'd5, 2'b01);
        push_b(14'h2, 2'b00);
        do_w('0, 32'h0000_000F, 1'b1);
        wait_b();
        push_r(14'h3, {{28{8'hFF}}, 32'h0000_0000}, 2'b00, 1'b1);
        do_ar(14'h3, 48'h8000_0000, 8'd0, 3'd5, 2'b01);
        wait_r();

        // ---- burst crossing the top of the window ----
        top_addr = 48'h8001_FFE0;
        do_aw(14'h4, top_addr, 8'd1, 3'd5, 2'b01);
        push_b(14'h4, 2'b11);
        do_w(rep32(32'h5555_0000), '1, 1'b0);
        do_w(rep32(32'h6666_0000), '1, 1'b1);
        wait_b();
        push_r(14'h5, rep32(32'h5555_0000), 2'b00, 1'b0);
        push_r(14'h5, '0, 2'b11, 1'b1);
        do_ar(14'h5, top_addr, 8'd1, 3'd5, 2'b01);
        wait_r();

        // ---- read backpressure ----
        do_aw(14'h6, 48'h8000_1000, 8'd7, 3'd5, 2'b01);
        push_b(14'h6, 2'b00);
        for (int k = 0; k < 8; k++) do_w(rep32(32'hB0 + k), '1, k == 7);
        wait_b();
        rready = 0;
        for (int k = 0; k < 8; k++) push_r(14'h7, rep32(32'hB0 + k), 2'b00, k == 7);
        do_ar(14'h7, 48'h8000_1000, 8'd7, 3'd5, 2'b01);
        beats = 0; cyc = 0; have_held = 0; held = '0;
        while (beats < 8 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (rvalid) begin
                if (have_held) chk("r_hold", rdata, held);
                have_held = 0;
                if (!rready) begin held = rdata; have_held = 1; end
                else beats++;
            end
            if (beats < 8) begin @(posedge clk); #1 rready = ~rready; end
        end
        chk("bp_beats", DATA_W'(beats), DATA_W'(8));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_arready", DATA_W'(arready), DATA_W'(1'b1));
        chk("bp_rvalid", DATA_W'(rvalid), '0);
        chk("bp_pending", DATA_W'(exp_r.size()), '0);
        rready = 1;

        // ---- WRAP burst must not write ----
        do_aw(14'h8, 48'h8000_2000, 8'd0, 3'd5, 2'b01);
        push_b(14'h8, 2'b00);
        do_w(rep32(32'h1111_1111), '1, 1'b1);
        wait_b();
        do_aw(14'h9, 48'h8000_2000, 8'd3, 3'd5, 2'b10);
        push_b(14'h9, 2'b10);
        for (int k = 0; k < 4; k++) do_w(rep32(32'hC0 + k), '1, k == 3);
        wait_b();
        push_r(14'hA, rep32(32'h1111_1111), 2'b00, 1'b1);
        do_ar(14'hA, 48'h8000_2000, 8'd0, 3'd5, 2'b01);
        wait_r();

        // ---- early wlast: still four beats, SLVERR ----
        do_aw(14'hB, 48'h8000_3000, 8'd3, 3'd5, 2'b01);
        push_b(14'hB, 2'b10);
        for (int k = 0; k < 4; k++) begin
            do_w(rep32(32'hD0 + k), '1, k == 1);
            if (k == 1) begin
                @(negedge clk);
                chk("wlast_wready_cont", DATA_W'(wready), DATA_W'(1'b1));
            end
        end
        @(negedge clk);
        chk("wlast_wready_end", DATA_W'(wready), '0);
        wait_b();

        // ---- reset in the middle of a stalled read ----
        rready = 0;
        do_ar(14'hC, 48'h8000_1000, 8'd7, 3'd5, 2'b01);
        @(negedge clk);
        chk("pre_rst_rvalid", DATA_W'(rvalid), DATA_W'(1'b1));
        @(posedge clk); #1 rst_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mid_rst_flags", DATA_W'(out_flags()), '0);
            chk("mid_rst_rdata", rdata, '0);
        end
        chk("mid_rst_ids", DATA_W'({bid, rid}), '0);
        rready = 1;
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_arready", DATA_W'(arready), DATA_W'(1'b1));
        chk("post_rst_awready", DATA_W'(awready), DATA_W'(1'b1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_rvalid", DATA_W'(rvalid), '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
